// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small TX FIFO and a configurable frame format.
// Words are accepted with valid/ready and sent back-to-back, LSB first.
module uart_tx_fifo #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 57600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [DATA_BITS-1:0]        i_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic                        o_uart_tx,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_level
);

  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW  = ($clog2(DIV) < 32'sd1) ? 32'sd1 : $clog2(DIV);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LW  = PW + 32'sd1;
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_RELOAD = CW'(DIV - 32'sd1);
  localparam logic [BW-1:0] LAST_DATA  = BW'(DATA_BITS - 32'sd1);
  localparam logic [BW-1:0] LAST_STOP  = BW'(STOP_BITS - 32'sd1);
  localparam logic [LW-1:0] LVL_FULL   = LW'(FIFO_DEPTH);

  if (DIV < 32'sd2) begin : g_bad_div
    $error("uart_tx_fifo: CLK_FREQ_HZ/BAUD_RATE must be at least 2");
  end
  if ((DATA_BITS < 32'sd5) || (DATA_BITS > 32'sd9)) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if ((PARITY < 32'sd0) || (PARITY > 32'sd2)) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS != 32'sd1) && (STOP_BITS != 32'sd2)) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if ((FIFO_DEPTH < 32'sd2) || ((FIFO_DEPTH & (FIFO_DEPTH - 32'sd1)) != 32'sd0)) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // Odd parity makes the total count of ones (data + parity) odd.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] word);
    logic even_s;
    even_s = ^word;
    if (PARITY == 32'sd1) begin
      parity_bit = ~even_s;
    end else begin
      parity_bit = even_s;
    end
  endfunction

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  ready_q, ready_d;
  logic [LW-1:0]         level_q, level_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0]  mem_d [FIFO_DEPTH];

  logic                  push_s;
  logic                  pop_s;
  logic                  bit_end_s;
  logic                  not_empty_s;
  logic [DATA_BITS-1:0]  head_s;

  // Frame sequencer, baud counter and FIFO bookkeeping.
  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_d       = par_q;
    tx_d        = tx_q;
    pop_s       = 1'b0;
    push_s      = i_valid & ready_q;
    bit_end_s   = (cnt_q == {CW{1'b0}});
    not_empty_s = (level_q != {LW{1'b0}});
    head_s      = mem_q[rd_ptr_q];

    if ((state_q != S_IDLE) && !bit_end_s) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      S_IDLE: begin
        if (not_empty_s) begin
          pop_s = 1'b1;
        end else begin
          tx_d = 1'b1;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_d = S_DATA;
          cnt_d   = CNT_RELOAD;
          bit_d   = {BW{1'b0}};
          tx_d    = shift_q[0];
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          cnt_d = CNT_RELOAD;
          if (bit_q == LAST_DATA) begin
            if (PARITY != 32'sd0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              bit_d   = {BW{1'b0}};
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (bit_end_s) begin
          state_d = S_STOP;
          cnt_d   = CNT_RELOAD;
          bit_d   = {BW{1'b0}};
          tx_d    = 1'b1;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          if (bit_q == LAST_STOP) begin
            if (not_empty_s) begin
              pop_s = 1'b1;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + BW'(1);
            cnt_d = CNT_RELOAD;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // A pop always starts a new frame on the same edge, from IDLE or the last stop bit.
    if (pop_s) begin
      state_d  = S_START;
      cnt_d    = CNT_RELOAD;
      bit_d    = {BW{1'b0}};
      shift_d  = head_s;
      par_d    = parity_bit(head_s);
      tx_d     = 1'b0;
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    mem_d = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    busy_d  = (state_d != S_IDLE);
    ready_d = (level_d != LVL_FULL);
  end

  // State registers; reset forces the line high and empties the FIFO.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      bit_q    <= {BW{1'b0}};
      shift_q  <= {DATA_BITS{1'b0}};
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      level_q  <= {LW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      mem_q    <= '{default: {DATA_BITS{1'b0}}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign o_uart_tx = tx_q;
  assign o_busy    = busy_q;
  assign o_ready   = ready_q;
  assign o_level   = level_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: three instances (8N1, 7E1, 7O2) at D = 10,
// line samples compared on the falling edge against a per-cycle expected waveform queue.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int D      = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din_a;
  logic       valid_a, ready_a, tx_a, busy_a;
  logic [2:0] level_a;
  logic [6:0] din_b;
  logic       valid_b, ready_b, tx_b, busy_b;
  logic [2:0] level_b;
  logic [6:0] din_c;
  logic       valid_c, ready_c, tx_c, busy_c;
  logic [2:0] level_c;

  int   checks   = 0;
  int   failures = 0;
  logic exp_q[$];

  always #500 clk = ~clk;

  uart_tx_fifo #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .i_clk(clk), .i_rst(rst_n), .i_data(din_a), .i_valid(valid_a), .o_ready(ready_a),
    .o_uart_tx(tx_a), .o_busy(busy_a), .o_level(level_a));

  uart_tx_fifo #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
    .i_clk(clk), .i_rst(rst_n), .i_data(din_b), .i_valid(valid_b), .o_ready(ready_b),
    .o_uart_tx(tx_b), .o_busy(busy_b), .o_level(level_b));

  uart_tx_fifo #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(1),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) dut_c (
    .i_clk(clk), .i_rst(rst_n), .i_data(din_c), .i_valid(valid_c), .o_ready(ready_c),
    .o_uart_tx(tx_c), .o_busy(busy_c), .o_level(level_c));

  function automatic logic tx_of(input int d);
    case (d)
      0:       return tx_a;
      1:       return tx_b;
      default: return tx_c;
    endcase
  endfunction

  function automatic logic busy_of(input int d);
    case (d)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  // Expected line level per clock for one frame: start, data LSB first, parity, stop(s).
  task automatic add_frame(input logic [8:0] w, input int nbits, input int par, input int nstop);
    int   ones = 0;
    logic pb;
    for (int k = 0; k < D; k++) exp_q.push_back(1'b0);
    for (int b = 0; b < nbits; b++) begin
      ones += int'(w[b]);
      for (int k = 0; k < D; k++) exp_q.push_back(w[b]);
    end
    if (par != 0) begin
      pb = (par == 2) ? ones[0] : ~ones[0];
      for (int k = 0; k < D; k++) exp_q.push_back(pb);
    end
    for (int k = 0; k < nstop * D; k++) exp_q.push_back(1'b1);
  endtask

  task automatic check_stream(input int d, input int n, input int busy_exp, input string name);
    int   busy_n = 0;
    logic e;
    logic t;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      t = tx_of(d);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'b1;
      checks++;
      if (t !== e) begin
        failures++;
        $display("FAIL %s tx sample %0d: got %b expected %b", name, i, t, e);
      end
      if (busy_of(d) === 1'b1) busy_n++;
    end
    checks++;
    if (busy_n != busy_exp) begin
      failures++;
      $display("FAIL %s busy cycles: got %0d expected %0d", name, busy_n, busy_exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    din_a = 8'h00; din_b = 7'h00; din_c = 7'h00;
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_a !== 1'b1)    begin failures++; $display("FAIL reset_tx: got %b expected 1", tx_a); end
    checks++; if (busy_a !== 1'b0)  begin failures++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    checks++; if (level_a !== 3'd0) begin failures++; $display("FAIL reset_level: got %0d expected 0", level_a); end
    checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", ready_a); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL release_ready_a: got %b expected 1", ready_a); end
    checks++; if (ready_b !== 1'b1) begin failures++; $display("FAIL release_ready_b: got %b expected 1", ready_b); end
    checks++; if (ready_c !== 1'b1) begin failures++; $display("FAIL release_ready_c: got %b expected 1", ready_c); end
    checks++; if (tx_a !== 1'b1)    begin failures++; $display("FAIL release_tx: got %b expected 1", tx_a); end
  endtask

  task automatic test_8n1(input logic [7:0] w, input string name);
    exp_q.delete();
    din_a = w; valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    din_a = ~w;
    checks++; if (tx_a !== 1'b1)    begin failures++; $display("FAIL %s idle_after_accept: got %b expected 1", name, tx_a); end
    checks++; if (level_a !== 3'd1) begin failures++; $display("FAIL %s level_after_accept: got %0d expected 1", name, level_a); end
    add_frame({1'b0, w}, 8, 0, 1);
    exp_q.push_back(1'b1);
    check_stream(0, 101, 100, name);
    checks++; if (level_a !== 3'd0) begin failures++; $display("FAIL %s level_end: got %0d expected 0", name, level_a); end
  endtask

  task automatic test_parity_even();
    exp_q.delete();
    din_b = 7'h07; valid_b = 1'b1;
    @(negedge clk);
    valid_b = 1'b0;
    checks++; if (tx_b !== 1'b1) begin failures++; $display("FAIL parity_even_idle: got %b expected 1", tx_b); end
    add_frame(9'h007, 7, 2, 1);
    exp_q.push_back(1'b1);
    check_stream(1, 101, 100, "parity_even");
  endtask

  task automatic test_stop2_back_to_back();
    logic e;
    exp_q.delete();
    din_c = 7'h07; valid_c = 1'b1;
    @(negedge clk);
    din_c = 7'h2A;
    checks++; if (level_c !== 3'd1) begin failures++; $display("FAIL stop2_level1: got %0d expected 1", level_c); end
    add_frame(9'h007, 7, 1, 2);
    add_frame(9'h02A, 7, 1, 2);
    exp_q.push_back(1'b1);
    @(negedge clk);
    valid_c = 1'b0;
    din_c = 7'h7F;
    e = exp_q.pop_front();
    checks++; if (tx_c !== e) begin failures++; $display("FAIL stop2_start: got %b expected %b", tx_c, e); end
    checks++; if (level_c !== 3'd1) begin failures++; $display("FAIL stop2_level2: got %0d expected 1", level_c); end
    check_stream(2, 220, 219, "stop2_b2b");
  endtask

  task automatic test_fill_and_full_pop();
    logic       will;
    logic       e;
    logic [8:0] w;
    int         acc   = 0;
    int         guard = 0;
    exp_q.delete();
    exp_q.push_back(1'b1);
    for (int k = 1; k <= 6; k++) begin
      w = 9'(k * 17);
      add_frame(w, 8, 0, 1);
    end
    exp_q.push_back(1'b1);
    din_a = 8'h11; valid_a = 1'b1;
    for (int i = 0; i < 12; i++) begin
      will = ready_a;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (tx_a !== e) begin failures++; $display("FAIL fill tx sample %0d: got %b expected %b", i, tx_a, e); end
      if (will) begin
        acc++;
        din_a = din_a + 8'h11;
      end
    end
    checks++; if (acc != 5)         begin failures++; $display("FAIL fill_accepted: got %0d expected 5", acc); end
    checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL fill_ready: got %b expected 0", ready_a); end
    checks++; if (level_a !== 3'd4) begin failures++; $display("FAIL fill_level: got %0d expected 4", level_a); end
    while (level_a == 3'd4 && guard < 200) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (tx_a !== e) begin failures++; $display("FAIL full_wait tx sample %0d: got %b expected %b", guard, tx_a, e); end
      guard++;
    end
    checks++; if (guard != 90)      begin failures++; $display("FAIL full_pop_cycle: got %0d expected 90", guard); end
    checks++; if (level_a !== 3'd3) begin failures++; $display("FAIL full_pop_level: got %0d expected 3", level_a); end
    checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL full_pop_ready: got %b expected 1", ready_a); end
    @(negedge clk);
    valid_a = 1'b0;
    e = exp_q.pop_front();
    checks++; if (tx_a !== e)       begin failures++; $display("FAIL late_accept tx: got %b expected %b", tx_a, e); end
    checks++; if (level_a !== 3'd4) begin failures++; $display("FAIL late_accept_level: got %0d expected 4", level_a); end
    check_stream(0, 499, 498, "fill_drain");
    checks++; if (level_a !== 3'd0) begin failures++; $display("FAIL drain_level: got %0d expected 0", level_a); end
  endtask

  task automatic test_reset_mid_frame();
    din_a = 8'h00; valid_a = 1'b1;
    repeat (4) @(negedge clk);
    valid_a = 1'b0;
    repeat (27) @(negedge clk);
    checks++; if (tx_a !== 1'b0)    begin failures++; $display("FAIL mid_data_tx: got %b expected 0", tx_a); end
    checks++; if (level_a !== 3'd3) begin failures++; $display("FAIL mid_data_level: got %0d expected 3", level_a); end
    checks++; if (busy_a !== 1'b1)  begin failures++; $display("FAIL mid_data_busy: got %b expected 1", busy_a); end
    #200;
    rst_n = 1'b0;
    #1;
    checks++; if (tx_a !== 1'b1)    begin failures++; $display("FAIL async_rst_tx: got %b expected 1", tx_a); end
    checks++; if (busy_a !== 1'b0)  begin failures++; $display("FAIL async_rst_busy: got %b expected 0", busy_a); end
    checks++; if (level_a !== 3'd0) begin failures++; $display("FAIL async_rst_level: got %0d expected 0", level_a); end
    checks++; if (ready_a !== 1'b0) begin failures++; $display("FAIL async_rst_ready: got %b expected 0", ready_a); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ready_a !== 1'b1) begin failures++; $display("FAIL post_rst_ready: got %b expected 1", ready_a); end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++;
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || level_a !== 3'd0) begin
        failures++;
        $display("FAIL post_rst_idle cycle %0d: got tx=%b busy=%b level=%0d expected tx=1 busy=0 level=0",
                 i, tx_a, busy_a, level_a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_8n1(8'h55, "frame_8n1_55");
    test_parity_even();
    test_stop2_back_to_back();
    test_fill_and_full_pop();
    test_reset_mid_frame();
    test_8n1(8'hA5, "frame_after_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
